// File: rtl/dequant_stream_pkg.sv
// Shared widths, int16 limits and the identity config for the dequantizer.
// The round/saturate helper reuses these, and so can the quant path.
package dequant_stream_pkg;

    localparam int DW_IN    = 8;
    localparam int DW_SCALE = 16;
    localparam int DW_SHIFT = 4;
    localparam int DW_OUT   = 16;
    localparam int CNT_W    = 16;

    // Width of (code - zero_point) and of the exact product with the scale.
    localparam int DW_DIFF  = DW_IN + 1;
    localparam int DW_PROD  = DW_DIFF + DW_SCALE;

    localparam int INT16_MAX = 32767;
    localparam int INT16_MIN = -32768;

    typedef struct packed {
        logic signed [DW_SCALE-1:0] scale;
        logic        [DW_SHIFT-1:0] shift;
        logic        [DW_IN-1:0]    zero_point;
    } dq_cfg_t;

    localparam dq_cfg_t CFG_RESET = '{scale: 16'sd1, shift: 4'd0, zero_point: 8'd0};

endpackage

// File: rtl/dequant_stream_if.sv
// Element stream carrying a data word and an end-of-tile marker.
// A beat transfers on a rising edge where valid && ready are both high.
interface dequant_stream_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/dequant_stream_round_sat.sv
// Round-half-up arithmetic right shift followed by saturation to int16.
// Purely combinational; sat flags that the result had to be clamped.
module dq_round_sat
    import dequant_stream_pkg::*;
#(
    parameter int P_W = DW_PROD,
    parameter int S_W = DW_SHIFT,
    parameter int O_W = DW_OUT
) (
    input  logic signed [P_W-1:0] p,
    input  logic        [S_W-1:0] shift,
    output logic signed [O_W-1:0] data,
    output logic                  sat
);

    // One guard bit so adding the rounding bias can never overflow.
    localparam int R_W = P_W + 1;

    logic signed [R_W-1:0] ext;
    logic signed [R_W-1:0] bias;
    logic signed [R_W-1:0] r;

    always_comb begin
        ext  = {p[P_W-1], p};
        bias = '0;
        if (shift != '0) begin
            bias = R_W'(1) << (shift - S_W'(1));
        end
        r    = (ext + bias) >>> shift;

        sat  = 1'b0;
        data = r[O_W-1:0];
        if (r > R_W'(INT16_MAX)) begin
            sat  = 1'b1;
            data = O_W'(INT16_MAX);
        end else if (r < R_W'(INT16_MIN)) begin
            sat  = 1'b1;
            data = O_W'(INT16_MIN);
        end
    end

endmodule

// File: rtl/dequant_stream.sv
// Streaming uint8 -> int16 dequantizer: (q - zp) * scale, rounded shift, saturate.
// Three register stages that advance together; each element carries its own scale/shift.
module dequant_stream
    import dequant_stream_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_load,
    input  logic [DW_SCALE-1:0] cfg_scale,
    input  logic [DW_SHIFT-1:0] cfg_shift,
    input  logic [DW_IN-1:0]    cfg_zero_point,
    dequant_stream_if.slave     in_if,
    dequant_stream_if.master    out_if,
    output logic [CNT_W-1:0]    sat_count,
    input  logic                sat_clear
);

    // Handshake: the whole pipe advances when the output register is empty or
    // being drained; in_ready is that enable, combinational from out_ready.
    logic en;
    logic acc;

    assign en          = !out_if.valid || out_if.ready;
    assign in_if.ready = en;
    assign acc         = in_if.valid && en;

    dq_cfg_t cfg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= CFG_RESET;
        end else if (cfg_load) begin
            cfg_q <= '{scale: $signed(cfg_scale), shift: cfg_shift, zero_point: cfg_zero_point};
        end
    end

    logic [DW_DIFF-1:0] diff_raw;
    assign diff_raw = {1'b0, in_if.data} - {1'b0, cfg_q.zero_point};

    logic                       s1_valid;
    logic signed [DW_DIFF-1:0]  s1_d;
    logic signed [DW_SCALE-1:0] s1_scale;
    logic        [DW_SHIFT-1:0] s1_shift;
    logic                       s1_last;

    logic                       s2_valid;
    logic signed [DW_PROD-1:0]  s2_p;
    logic        [DW_SHIFT-1:0] s2_shift;
    logic                       s2_last;

    logic signed [DW_OUT-1:0]   rs_data;
    logic                       rs_sat;

    dq_round_sat #(
        .P_W (DW_PROD),
        .S_W (DW_SHIFT),
        .O_W (DW_OUT)
    ) u_round_sat (
        .p     (s2_p),
        .shift (s2_shift),
        .data  (rs_data),
        .sat   (rs_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_d         <= '0;
            s1_scale     <= '0;
            s1_shift     <= '0;
            s1_last      <= 1'b0;
            s2_valid     <= 1'b0;
            s2_p         <= '0;
            s2_shift     <= '0;
            s2_last      <= 1'b0;
            out_if.valid <= 1'b0;
            out_if.data  <= '0;
            out_if.last  <= 1'b0;
        end else if (en) begin
            s1_valid     <= acc;
            s1_d         <= $signed(diff_raw);
            s1_scale     <= cfg_q.scale;
            s1_shift     <= cfg_q.shift;
            s1_last      <= in_if.last;

            s2_valid     <= s1_valid;
            s2_p         <= DW_PROD'(s1_d) * DW_PROD'(s1_scale);
            s2_shift     <= s1_shift;
            s2_last      <= s1_last;

            out_if.valid <= s2_valid;
            out_if.data  <= rs_data;
            out_if.last  <= s2_last;
        end
    end

    // Clear wins over a same-cycle increment; the counter parks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || sat_clear) begin
            sat_count <= '0;
        end else if (en && s2_valid && rs_sat && (sat_count != '1)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dequant_stream.sv
// Bench for dequant_stream: directed corner cases plus randomized traffic
// against an arithmetic reference model with an expected-output queue.
module tb_dequant_stream;
    import dequant_stream_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_load = 1'b0;
    logic [DW_SCALE-1:0] cfg_scale = '0;
    logic [DW_SHIFT-1:0] cfg_shift = '0;
    logic [DW_IN-1:0]    cfg_zp = '0;
    logic                sat_clear = 1'b0;
    logic [CNT_W-1:0]    sat_count;

    dequant_stream_if #(.W(DW_IN))  in_if ();
    dequant_stream_if #(.W(DW_OUT)) out_if ();

    dequant_stream dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_load       (cfg_load),
        .cfg_scale      (cfg_scale),
        .cfg_shift      (cfg_shift),
        .cfg_zero_point (cfg_zp),
        .in_if          (in_if),
        .out_if         (out_if),
        .sat_count      (sat_count),
        .sat_clear      (sat_clear)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [17:0] exp_q[$];  // {sat, last, data}
    int          out_hist[$];
    int          m_scale = 1;
    int          m_shift = 0;
    int          m_zp = 0;
    int          sat_exp = 0;
    int          n_out = 0;
    int          acc_cyc = 0;
    logic [17:0] e;

    // Reference: exact integer arithmetic, floor division after adding half.
    function automatic logic [17:0] model(input int q, input logic last);
        longint d, p, r;
        logic   s;
        d = longint'(q - m_zp);
        p = d * longint'(m_scale);
        if (m_shift == 0) r = p;
        else r = (p + (longint'(1) << (m_shift - 1))) >>> m_shift;
        s = 1'b0;
        if (r > 32767) begin r = 32767; s = 1'b1; end
        else if (r < -32768) begin r = -32768; s = 1'b1; end
        return {s, last, r[15:0]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_scale = 1;
            m_shift = 0;
            m_zp    = 0;
            sat_exp = 0;
        end else begin
            // Accept uses the config as it stands this cycle; cfg_load applies afterwards.
            if (in_if.valid && in_if.ready) begin
                exp_q.push_back(model(int'(in_if.data), in_if.last));
                acc_cyc = cyc;
            end
            if (out_if.valid && out_if.ready) begin
                n_out++;
                out_hist.push_back(int'($signed(out_if.data)));
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", $signed(out_if.data), $signed(e[15:0]));
                    check("out_last", out_if.last, e[16]);
                    if (e[17]) sat_exp++;
                end
            end
            if (cfg_load) begin
                m_scale = int'($signed(cfg_scale));
                m_shift = int'(cfg_shift);
                m_zp    = int'(cfg_zp);
            end
            if (sat_clear) sat_exp = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int scale, input int shift, input int zp);
        cfg_scale = DW_SCALE'(scale);
        cfg_shift = DW_SHIFT'(shift);
        cfg_zp    = DW_IN'(zp);
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic send(input logic [7:0] q, input logic last, input logic do_cfg);
        int   budget;
        logic ok;
        in_if.valid = 1'b1;
        in_if.data  = q;
        in_if.last  = last;
        cfg_load    = do_cfg;
        budget = 0;
        ok     = 1'b0;
        while (!ok && budget < 300) begin
            @(negedge clk);
            ok = in_if.ready;
            tick();
            cfg_load = 1'b0;
            budget++;
        end
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
        if (!ok) check("send_timeout", 1, 0);
    endtask

    task automatic wait_drain();
        out_if.ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_if.valid) break;
        end
        check("drain", exp_q.size(), 0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    int  n0;
    bit  rand_done;

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_if.valid, 0);
        check("rst_out_data", out_if.data, 0);
        check("rst_out_last", out_if.last, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_in_ready", in_if.ready, 1);
        tick();

        // Directed arithmetic corners
        set_cfg(16384, 14, 128);
        send(8'd130, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (out_if.valid) break;
        end
        check("latency", cyc - acc_cyc, 3);
        wait_drain();
        check("q130", out_hist[$], 2);

        set_cfg(3, 1, 128);
        send(8'd129, 1'b0, 1'b0);
        send(8'd127, 1'b0, 1'b0);
        wait_drain();
        check("q129", out_hist[$-1], 2);
        check("q127", out_hist[$], -1);

        set_cfg(32767, 0, 0);
        send(8'd255, 1'b1, 1'b0);
        wait_drain();
        check("sat_pos", out_hist[$], 32767);
        check("sat_count_1", sat_count, 1);

        set_cfg(32767, 0, 255);
        send(8'd0, 1'b0, 1'b0);
        wait_drain();
        check("sat_neg", out_hist[$], -32768);
        check("sat_count_2", sat_count, 2);
        check("sat_count_model", sat_count, sat_exp);

        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        check("sat_clear", sat_count, 0);

        // Backpressure: out_ready low in cycles 2..6 of an 8-element burst
        set_cfg(1, 0, 0);
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'(10 + i), (i == 7), 1'b0);
            end
            begin
                tick();
                tick();
                out_if.ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    if (out_if.valid) check("in_ready_stall", in_if.ready, 0);
                    tick();
                end
                out_if.ready = 1'b1;
            end
        join
        wait_drain();
        check("stall_count", n_out - n0, 8);
        check("stall_first", out_hist[$-7], 10);
        check("stall_last", out_hist[$], 17);

        // Config change between two elements
        set_cfg(1, 0, 100);
        send(8'd110, 1'b0, 1'b0);
        set_cfg(2, 0, 100);
        send(8'd110, 1'b0, 1'b0);
        wait_drain();
        check("cfg_old_scale", out_hist[$-1], 10);
        check("cfg_new_scale", out_hist[$], 20);

        // Randomized traffic with random backpressure and config reloads
        n0 = n_out;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    if ($urandom_range(0, 7) == 0) begin
                        cfg_scale = DW_SCALE'($urandom);
                        cfg_shift = DW_SHIFT'($urandom_range(0, 15));
                        cfg_zp    = DW_IN'($urandom);
                        send(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
                    end else begin
                        send(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_if.ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        wait_drain();
        check("rand_count", n_out - n0, 300);
        check("rand_sat_count", sat_count, sat_exp);

        // Reset with three elements in flight
        set_cfg(1, 0, 0);
        out_if.ready = 1'b0;
        send(8'd1, 1'b0, 1'b0);
        send(8'd2, 1'b0, 1'b0);
        send(8'd3, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", out_if.valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", out_if.valid, 0);
        check("post_rst_sat", sat_count, 0);
        n0 = n_out;
        out_if.ready = 1'b1;
        repeat (10) tick();
        check("no_residual", n_out - n0, 0);
        set_cfg(3, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(8'd42, 1'b1, 1'b0);
        wait_drain();
        check("rst_cfg_identity", out_hist[$], 42);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
